// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared FSM encoding and register constants for the pipeline sequencer
package pipeline_ctrl_pkg;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      HALT     = 2'd3
   } state_t;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs, stage controls and statistics between pipeline and sequencer
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
   logic             idex_memread_i;
   logic [4:0]       idex_rt_i;
   logic [4:0]       ifid_rs_i;
   logic [4:0]       ifid_rt_i;
   logic             ifid_uses_rt_i;
   logic             branch_taken_i;
   logic             dmem_req_i;
   logic             dmem_ack_i;
   logic             pc_write_o;
   logic             ifid_write_o;
   logic             ifid_flush_o;
   logic             idex_bubble_o;
   logic             pipe_hold_o;
   logic             memwb_bubble_o;
   logic             fault_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;
   modport master (
      output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
             branch_taken_i, dmem_req_i, dmem_ack_i,
      input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
             memwb_bubble_o, fault_o, stall_cnt_o, flush_cnt_o
   );
   modport slave (
      input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
             branch_taken_i, dmem_req_i, dmem_ack_i,
      output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
             memwb_bubble_o, fault_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the ID/EX load and the IF/ID sources
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic       memread,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       uses_rt,
   output logic       load_use
);
   assign load_use = memread && ex_rt != REG_ZERO && (ex_rt == id_rs || (uses_rt && ex_rt == id_rt));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer arbitrating memory wait, load-use and taken-branch hazards
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 8
) (
   input  logic           clk_i,
   input  logic           start_i,
   pipeline_ctrl_if.slave bus
);
   state_t           state, state_nx;
   logic [TO_W-1:0]  to_cnt;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic             fault, load_use, mem_wait, to_hit;
   logic             run, ok, frz, br, stall_inc, flush_inc;
   hazard_detect u_hazard (
      .memread  (bus.idex_memread_i),
      .ex_rt    (bus.idex_rt_i),
      .id_rs    (bus.ifid_rs_i),
      .id_rt    (bus.ifid_rt_i),
      .uses_rt  (bus.ifid_uses_rt_i),
      .load_use (load_use)
   );
   assign mem_wait = bus.dmem_req_i && !bus.dmem_ack_i;
   assign to_hit   = to_cnt == TO_W'(MEM_TIMEOUT);
   always_ff @(posedge clk_i or negedge start_i)
      if (!start_i) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     state_nx = RUN;
         RUN:      state_nx = mem_wait ? MEM_WAIT : RUN;
         MEM_WAIT: state_nx = bus.dmem_ack_i ? RUN : to_hit ? HALT : MEM_WAIT;
         HALT:     state_nx = HALT;
      endcase
   end
   always_comb begin
      run                = state == RUN;
      ok                 = run && !mem_wait && !load_use;
      frz                = state == MEM_WAIT || state == HALT || (run && mem_wait);
      br                 = ok && bus.branch_taken_i;
      stall_inc          = (run && !ok) || state == MEM_WAIT;
      flush_inc          = br;
      bus.pc_write_o     = ok;
      bus.ifid_write_o   = ok;
      bus.ifid_flush_o   = state == IDLE || br;
      bus.idex_bubble_o  = state == IDLE || (run && !mem_wait && load_use);
      bus.pipe_hold_o    = frz;
      bus.memwb_bubble_o = state == IDLE || frz;
   end
   always_ff @(posedge clk_i or negedge start_i)
      if (!start_i) begin
         to_cnt    <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
         fault     <= 1'b0;
      end else begin
         if (run && mem_wait) to_cnt <= TO_W'(1);
         else if (state == MEM_WAIT && !bus.dmem_ack_i && !to_hit) to_cnt <= to_cnt + TO_W'(1);
         if (state == MEM_WAIT && !bus.dmem_ack_i && to_hit) fault <= 1'b1;
         if (stall_inc && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   assign bus.fault_o     = fault;
   assign bus.stall_cnt_o = stall_cnt;
   assign bus.flush_cnt_o = flush_cnt;
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the PC write enable (pcWrite_i of the PC register) and the IF/ID, ID/EX, EX/MEM and MEM/WB write and bubble controls.
- Arbitrates three hazard sources: data-memory wait, load-use, and taken branch.
- Detects a hung memory handshake and exposes stall/flush statistics counters.

Parameters:
- CNT_W, 16: width of the saturating statistics counters.
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before a fault is declared; legal range 1..2^TO_W-1.
- TO_W, 8: width of the timeout counter.

Ports:
- clk_i  in  1  system clock; all state updates on posedge.
- start_i  in  1  asynchronous active-low reset. 0 = reset; pipeline runs while 1.
- idex_memread_i  in  1  the instruction in ID/EX is a load.
- idex_rt_i  in  5  load destination register in ID/EX.
- ifid_rs_i  in  5  rs field of the instruction in IF/ID.
- ifid_rt_i  in  5  rt field of the instruction in IF/ID.
- ifid_uses_rt_i  in  1  the IF/ID instruction reads rt as a source.
- branch_taken_i  in  1  a branch resolved taken in ID this cycle.
- dmem_req_i  in  1  the EX/MEM instruction accesses data memory.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID register write enable.
- ifid_flush_o  out  1  zero IF/ID on the next edge.
- idex_bubble_o  out  1  load a NOP into ID/EX.
- pipe_hold_o  out  1  hold ID/EX and EX/MEM contents.
- memwb_bubble_o  out  1  load a NOP into MEM/WB.
- fault_o  out  1  sticky memory-timeout fault.
- stall_cnt_o  out  CNT_W  count of stall cycles.
- flush_cnt_o  out  CNT_W  count of flush events.

Behaviour:
- FSM states: IDLE, RUN, MEM_WAIT, HALT. State, counters and fault are registered; control outputs are combinational from state and inputs.
- Reset (start_i=0, asynchronous, may occur mid-operation):
  - State becomes IDLE; timeout counter, stall_cnt_o, flush_cnt_o and fault_o clear to 0.
  - While start_i=0, all control outputs are forced: pc_write_o=0, ifid_write_o=0, pipe_hold_o=0, ifid_flush_o=1, idex_bubble_o=1, memwb_bubble_o=1.
- IDLE:
  - Outputs as in reset.
  - Unconditionally goes to RUN on the next edge. This gives one bubble-filled cycle so the PC starts at 0 with empty stages.
- RUN, priority ordering:
  - 1) Memory wait, when dmem_req_i & !dmem_ack_i:
    - pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, memwb_bubble_o=1.
    - The load-use and branch outputs are suppressed.
    - Next state MEM_WAIT; timeout counter loads 1; stall_cnt_o increments.
  - 2) Load-use hazard, when idex_memread_i & idex_rt_i!=0 & (idex_rt_i==ifid_rs_i | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i)):
    - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
    - branch_taken_i is ignored this cycle; the branch is re-evaluated after the stall.
    - stall_cnt_o increments.
  - 3) branch_taken_i: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1; flush_cnt_o increments.
  - 4) Otherwise: pc_write_o=1, ifid_write_o=1; all other controls 0.
  - A memory request acknowledged in the same cycle (dmem_req_i & dmem_ack_i) causes no stall.
- MEM_WAIT:
  - Freeze outputs as in RUN case 1.
  - If dmem_ack_i=1: this cycle is still frozen; the next state is RUN and normal flow resumes on the following cycle. stall_cnt_o increments for every MEM_WAIT cycle.
  - Else, if the timeout counter equals MEM_TIMEOUT: next state HALT, fault_o is set to 1.
  - Else the timeout counter increments.
- HALT:
  - Outputs: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, memwb_bubble_o=1; fault_o stays 1.
  - All inputs are ignored; only reset exits HALT.
  - Statistics counters do not count in HALT.
- Counters saturate at 2^CNT_W-1 and never wrap.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, MEM_WAIT=2'd2, HALT=2'd3).
  - The constant REG_ZERO=5'd0.
- One sub-module, hazard_detect: the purely combinational load-use compare, producing a single load_use signal. It is reusable by the forwarding unit.

Test Plan:
- Reset then release: start_i 0→1 → one IDLE cycle (pc_write_o=0, ifid_flush_o=1), then RUN with pc_write_o=1 and all counters 0.
- Load-use: idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 → exactly one cycle of pc_write_o=0, idex_bubble_o=1; stall_cnt_o=1. Repeat with idex_rt_i=0 → no stall.
- Taken branch alone → ifid_flush_o=1 for 1 cycle, pc_write_o=1, flush_cnt_o=1. Branch together with a load-use hazard → stall only, flush_cnt_o unchanged.
- Memory wait: dmem_req_i=1, ack arrives 3 cycles later → 4 frozen cycles (RUN plus 3 MEM_WAIT), then normal flow; stall_cnt_o=4. Same-cycle ack → 0 stalls.
- Timeout: MEM_TIMEOUT=4, ack never asserted → fault_o rises after the 4th MEM_WAIT cycle. The machine stays in HALT despite a late ack, and clears only on start_i=0.
- Reset mid-MEM_WAIT and counter saturation: start_i=0 asynchronously clears everything. With CNT_W=4, 20 stall cycles → stall_cnt_o=15.
